// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states and
// the alignment rule applied at request acceptance.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Misaligned half/word or the reserved size code; such requests never reach the RAM.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SIZE_HALF: err = off[0];
      SIZE_WORD: err = (off != 2'b00);
      SIZE_RSVD: err = 1'b1;
      default:   err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Little-endian byte-lane steering: load extract/extend and sub-word store merge
// against a full 32-bit RAM word. Purely combinational.
module byte_lane_unit
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word_i[{off_i, 3'b000} +: 8];
  assign lane_h = word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    case (size_i)
      SIZE_BYTE: ld_data_o = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
      SIZE_HALF: ld_data_o = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
      default:   ld_data_o = word_i;
    endcase
  end

  // Only the addressed lane takes store data; the rest of the word is preserved.
  always_comb begin
    st_data_o = word_i;
    case (size_i)
      SIZE_BYTE: st_data_o[{off_i, 3'b000} +: 8]   = wdata_i[7:0];
      SIZE_HALF: st_data_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:   st_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for the word-addressed data RAM: one request in flight,
// loads aligned to the RAM read latency, sub-word stores done as read-modify-write.
//
// state       | meaning
// ST_IDLE     | req_ready high, waiting for valid&&ready
// ST_RD_ISSUE | ram_read_en asserted for this single cycle
// ST_RD_WAIT  | counting down RAM read latency, capture data_out on exit
// ST_WRITE    | ram_write_en asserted for this single cycle
// ST_RESP     | resp_valid pulse, then back to idle
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_q;
  logic                    uns_q;
  logic [1:0]              size_q;
  logic [1:0]              off_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    ram_write_en_q;
  logic                    ram_read_en_q;
  logic [ADDR_WIDTH-1:0]   ram_address_q;
  logic [DATA_WIDTH-1:0]   ram_data_in_q;

  logic                    accept;
  logic                    acc_err;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic [DATA_WIDTH-1:0]   st_data;

  assign accept  = req_valid && req_ready_q;
  assign acc_err = req_is_err(req_size, req_addr[1:0]);

  byte_lane_unit u_lane (
    .word_i     (ram_data_out),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_data_o  (st_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      wr_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= SIZE_BYTE;
      off_q          <= 2'b00;
      wdata_q        <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      ram_write_en_q <= 1'b0;
      ram_read_en_q  <= 1'b0;
      ram_address_q  <= '0;
      ram_data_in_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q          <= req_write;
            size_q        <= req_size;
            uns_q         <= req_unsigned;
            off_q         <= req_addr[1:0];
            wdata_q       <= req_wdata;
            ram_address_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            req_ready_q   <= 1'b0;
            resp_rdata_q  <= '0;
            if (acc_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= ST_RESP;
            end else if (req_write && (req_size == SIZE_WORD)) begin
              ram_write_en_q <= 1'b1;
              ram_data_in_q  <= req_wdata;
              state_q        <= ST_WRITE;
            end else begin
              ram_read_en_q <= 1'b1;
              state_q       <= ST_RD_ISSUE;
            end
          end
        end
        ST_RD_ISSUE: begin
          ram_read_en_q <= 1'b0;
          cnt_q         <= CNT_W'(RD_LATENCY);
          state_q       <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Terminal count 1 lines up with the cycle RAM data_out is valid.
          if (cnt_q == CNT_W'(1)) begin
            if (wr_q) begin
              ram_write_en_q <= 1'b1;
              ram_data_in_q  <= st_data;
              state_q        <= ST_WRITE;
            end else begin
              resp_rdata_q <= ld_data;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          ram_write_en_q <= 1'b0;
          resp_valid_q   <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign ram_write_en = ram_write_en_q;
  assign ram_read_en  = ram_read_en_q;
  assign ram_address  = ram_address_q;
  assign ram_data_in  = ram_data_in_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model with 2-cycle read latency, a per-cycle
// timeline model derived from request rules, and directed literal checks.
module tb_mem_access_ctrl;

  localparam int RDL  = 2;
  localparam int MAXC = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_write_en, ram_read_en;
  logic [31:0] ram_address, ram_data_in, ram_data_out;
  logic        init_done;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(RDL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // RAM: data_out valid two cycles after the read_en cycle
  logic [31:0] mem [16];
  logic [31:0] rd_p1, rd_p2;
  assign ram_data_out = rd_p2;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (ram_write_en) begin
      mem[ram_address[5:2]] <= ram_data_in;
    end
    if (ram_read_en) rd_p1 <= mem[ram_address[5:2]];
    rd_p2 <= rd_p1;
  end

  // Model
  typedef struct packed {
    logic [7:0]  lat;
    logic        err;
    logic        rd;
    logic        wr;
    logic [31:0] din;
    logic [31:0] rdata;
    logic [31:0] waddr;
    logic [3:0]  widx;
  } sched_t;

  function automatic logic [31:0] m_load(input logic [31:0] w, input int off,
                                         input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input int off,
                                          input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    m = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    return (w & ~(m << (8 * off))) | ((wd & m) << (8 * off));
  endfunction

  function automatic sched_t plan(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] cur);
    sched_t s;
    int off;
    off = int'(a[1:0]);
    s = '0;
    s.waddr = a & 32'hFFFFFFFC;
    s.widx  = a[5:2];
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0)) begin
      s.lat = 8'd1; s.err = 1'b1;
    end else if (w && sz == 2'd2) begin
      s.lat = 8'd2; s.wr = 1'b1; s.din = wd;
    end else if (w) begin
      s.lat = 8'(3 + RDL); s.rd = 1'b1; s.wr = 1'b1; s.din = m_store(cur, off, sz, wd);
    end else begin
      s.lat = 8'(2 + RDL); s.rd = 1'b1; s.rdata = m_load(cur, off, sz, u);
    end
    return s;
  endfunction

  logic [31:0] mmem [16];
  sched_t      ps;
  assign ps = plan(req_write, req_size, req_unsigned, req_addr, req_wdata, mmem[req_addr[5:2]]);

  int          cyc = 0;
  bit          exp_ready [MAXC];
  bit          exp_rd    [MAXC];
  bit          exp_wr    [MAXC];
  bit          exp_resp  [MAXC];
  bit          exp_err   [MAXC];
  logic [31:0] exp_rdata [MAXC];
  logic [31:0] exp_din   [MAXC];
  logic [31:0] exp_addr  [MAXC];
  bit          pend_v;
  int          pend_cyc;
  logic [3:0]  pend_idx;
  logic [31:0] pend_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = cyc; i < MAXC; i++) begin
        exp_ready[i] <= 1'b1; exp_rd[i] <= 1'b0; exp_wr[i] <= 1'b0;
        exp_resp[i] <= 1'b0; exp_err[i] <= 1'b0;
      end
      pend_v <= 1'b0;
      if (!init_done) for (int i = 0; i < 16; i++) mmem[i] <= 32'h0;
    end else begin
      if (pend_v && pend_cyc == cyc) begin
        mmem[pend_idx] <= pend_val;
        pend_v <= 1'b0;
      end
      if (req_valid && exp_ready[cyc] && cyc < MAXC - 16) begin
        for (int k = 1; k <= int'(ps.lat); k++) begin
          exp_ready[cyc + k] <= 1'b0;
          exp_addr[cyc + k]  <= ps.waddr;
        end
        exp_resp[cyc + int'(ps.lat)]  <= 1'b1;
        exp_err[cyc + int'(ps.lat)]   <= ps.err;
        exp_rdata[cyc + int'(ps.lat)] <= ps.rdata;
        if (ps.rd) exp_rd[cyc + 1] <= 1'b1;
        if (ps.wr) begin
          exp_wr[cyc + int'(ps.lat) - 1]  <= 1'b1;
          exp_din[cyc + int'(ps.lat) - 1] <= ps.din;
          pend_v   <= 1'b1;
          pend_cyc <= cyc + int'(ps.lat) - 1;
          pend_idx <= ps.widx;
          pend_val <= ps.din;
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Checking
  int          n_chk = 0;
  int          n_pass = 0;
  int          g_rd, g_wr, g_acc, g_rsp;
  logic [31:0] g_din, g_rdata;
  logic        g_err;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, expv);
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc < MAXC) begin
      chk($sformatf("req_ready@%0d", cyc), 32'(req_ready), 32'(exp_ready[cyc]));
      chk($sformatf("ram_read_en@%0d", cyc), 32'(ram_read_en), 32'(exp_rd[cyc]));
      chk($sformatf("ram_write_en@%0d", cyc), 32'(ram_write_en), 32'(exp_wr[cyc]));
      chk($sformatf("resp_valid@%0d", cyc), 32'(resp_valid), 32'(exp_resp[cyc]));
      if (exp_resp[cyc]) begin
        chk($sformatf("resp_err@%0d", cyc), 32'(resp_err), 32'(exp_err[cyc]));
        chk($sformatf("resp_rdata@%0d", cyc), resp_rdata, exp_rdata[cyc]);
      end
      if (exp_wr[cyc]) chk($sformatf("ram_data_in@%0d", cyc), ram_data_in, exp_din[cyc]);
      if (!exp_ready[cyc]) chk($sformatf("ram_address@%0d", cyc), ram_address, exp_addr[cyc]);
    end
    if (ram_read_en) g_rd++;
    if (ram_write_en) begin g_wr++; g_din = ram_data_in; end
    if (resp_valid) begin g_rsp = cyc; g_rdata = resp_rdata; g_err = resp_err; end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    g_rd = 0; g_wr = 0; g_acc = -1; g_rsp = -1; g_din = 'x; g_rdata = 'x; g_err = 'x;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && g_rsp < 0; i++) begin
      if (g_acc < 0 && exp_ready[cyc]) g_acc = cyc;
      tick();
      if (g_acc >= 0 && !hold) req_valid = 1'b0;
    end
    if (g_rsp < 0) begin
      n_chk++;
      $display("FAIL resp_timeout: no resp_valid for addr %h, required one within 40 cycles", a);
    end
  endtask

  task automatic chk_lat(input string nm, input int expv);
    chk({nm, "_latency"}, 32'(g_rsp - g_acc), 32'(expv));
  endtask

  initial begin
    init_done = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_write_en", 32'(ram_write_en), 32'd0);
    chk("rst_ram_read_en", 32'(ram_read_en), 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    chk("rst_ram_data_in", ram_data_in, 32'd0);
    init_done = 1'b1;
    rst_n = 1'b1;
    tick();

    // preload word 1
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h8899AABB, 1'b0);
    chk_lat("preload", 2);

    do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 1'b0);
    chk("lb_s_rdata", g_rdata, 32'hFFFFFFAA);
    chk("lb_s_err", 32'(g_err), 32'd0);
    chk_lat("lb_s", 4);
    chk("lb_s_read_cycles", 32'(g_rd), 32'd1);

    do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 1'b0);
    chk("lh_u_rdata", g_rdata, 32'h00008899);

    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0);
    chk("lw_rdata", g_rdata, 32'h8899AABB);

    do_req(1'b1, 2'd0, 1'b0, 32'h7, 32'hFFFFFF11, 1'b0);
    chk("sb_write_cycles", 32'(g_wr), 32'd1);
    chk("sb_ram_data_in", g_din, 32'h1199AABB);
    chk("sb_rdata", g_rdata, 32'h0);
    chk_lat("sb", 5);

    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0);
    chk("lw_after_sb", g_rdata, 32'h1199AABB);

    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 1'b1);
    chk_lat("sw", 2);
    chk("sw_read_cycles", 32'(g_rd), 32'd0);
    chk("sw_write_cycles", 32'(g_wr), 32'd1);
    begin
      int rsp1;
      rsp1 = g_rsp;
      do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0);
      chk("b2b_accept_cycle", 32'(g_acc), 32'(rsp1 + 1));
    end

    do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0);
    chk("err_lw_err", 32'(g_err), 32'd1);
    chk("err_lw_rdata", g_rdata, 32'h0);
    chk_lat("err_lw", 1);
    chk("err_lw_ram_en", 32'(g_rd + g_wr), 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1'b0);
    chk("err_lh_err", 32'(g_err), 32'd1);
    chk_lat("err_lh", 1);
    chk("err_lh_ram_en", 32'(g_rd + g_wr), 32'd0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h12345678, 1'b0);
    chk("err_rsvd_err", 32'(g_err), 32'd1);
    chk("err_rsvd_rdata", g_rdata, 32'h0);
    chk_lat("err_rsvd", 1);
    chk("err_rsvd_ram_en", 32'(g_rd + g_wr), 32'd0);

    // Half store aborted by reset during RD_WAIT
    g_rd = 0; g_wr = 0; g_acc = -1; g_rsp = -1;
    req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h00005555; req_valid = 1'b1;
    for (int i = 0; i < 10 && g_acc < 0; i++) begin
      if (exp_ready[cyc]) g_acc = cyc;
      tick();
    end
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_write_en", 32'(ram_write_en), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("rst_mid_no_resp", 32'(g_rsp), 32'hFFFFFFFF);
    chk("rst_mid_no_write", 32'(g_wr), 32'd0);
    chk("rst_mid_ram_word", mem[1], 32'h1199AABB);

    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0);
    chk("lw_after_abort", g_rdata, 32'h1199AABB);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
